// File: rtl/onchip_memory_port_arbiter_if.sv
// Two-requester memory bus plus the shared single-port RAM port.
// ONCHIP_ARB_LOCK_EN adds the m0_lock/m1_lock requester inputs.
interface onchip_memory_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_address;
    logic [ADDR_W-1:0]   m1_address;
    logic [DATA_W/8-1:0] m0_byteenable;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m0_read;
    logic                m1_read;
    logic                m0_write;
    logic                m1_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic [DATA_W-1:0]   m1_writedata;
    logic                m0_waitrequest;
    logic                m1_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m0_readdatavalid;
    logic                m1_readdatavalid;
    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic [DATA_W-1:0]   ram_writedata;
    logic                ram_chipselect;
    logic                ram_write;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;
`ifdef ONCHIP_ARB_LOCK_EN
    logic                m0_lock;
    logic                m1_lock;
`endif

    modport master (
`ifdef ONCHIP_ARB_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output m0_address, m1_address, m0_byteenable, m1_byteenable,
        output m0_read, m1_read, m0_write, m1_write,
        output m0_writedata, m1_writedata, ram_readdata,
        input  m0_waitrequest, m1_waitrequest,
        input  m0_readdata, m1_readdata,
        input  m0_readdatavalid, m1_readdatavalid,
        input  ram_address, ram_byteenable, ram_writedata,
        input  ram_chipselect, ram_write, ram_clken
    );

    modport slave (
`ifdef ONCHIP_ARB_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  m0_address, m1_address, m0_byteenable, m1_byteenable,
        input  m0_read, m1_read, m0_write, m1_write,
        input  m0_writedata, m1_writedata, ram_readdata,
        output m0_waitrequest, m1_waitrequest,
        output m0_readdata, m1_readdata,
        output m0_readdatavalid, m1_readdatavalid,
        output ram_address, ram_byteenable, ram_writedata,
        output ram_chipselect, ram_write, ram_clken
    );
endinterface

// File: rtl/onchip_memory_port_arbiter.sv
// Round-robin arbiter sharing one on-chip RAM port between two requesters.
// Define ONCHIP_ARB_LOCK_EN to enable exclusive locked ownership.
module onchip_memory_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_req,
    onchip_memory_port_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

`ifdef ONCHIP_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LAST0 = 2'd0, LAST1 = 2'd1, LOCK0 = 2'd2, LOCK1 = 2'd3
    } state_t;
`else
    typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              r_rdv0;
    logic              r_rdv1;
    logic [ADDR_W-1:0] r_addr;
    logic              w_req0;
    logic              w_req1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_block;
    logic              w_prev0;
    logic              w_hold0;
    logic              w_hold1;

    assign w_req0  = bus.m0_read | bus.m0_write;
    assign w_req1  = bus.m1_read | bus.m1_write;
    assign w_block = reset | reset_req;
    assign w_acc   = w_gnt0 | w_gnt1;

`ifdef ONCHIP_ARB_LOCK_EN
    // Owner keeps the port while it asserts lock or is still issuing.
    assign w_hold0 = (r_state == LOCK0) & (bus.m0_lock | w_req0);
    assign w_hold1 = (r_state == LOCK1) & (bus.m1_lock | w_req1);
    assign w_prev0 = (r_state == LAST0) | (r_state == LOCK0);
`else
    assign w_hold0 = 1'b0;
    assign w_hold1 = 1'b0;
    assign w_prev0 = (r_state == LAST0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LAST1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
`ifdef ONCHIP_ARB_LOCK_EN
        if (w_gnt0) begin
            w_next = bus.m0_lock ? LOCK0 : LAST0;
        end else if (w_gnt1) begin
            w_next = bus.m1_lock ? LOCK1 : LAST1;
        end else if (!w_block && r_state == LOCK0 && !w_hold0) begin
            w_next = LAST0;
        end else if (!w_block && r_state == LOCK1 && !w_hold1) begin
            w_next = LAST1;
        end
`else
        if (w_gnt0) begin
            w_next = LAST0;
        end else if (w_gnt1) begin
            w_next = LAST1;
        end
`endif
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_block) begin
            if (w_hold0) begin
                w_gnt0 = w_req0;
            end else if (w_hold1) begin
                w_gnt1 = w_req1;
            end else if (w_req0 & w_req1) begin
                w_gnt0 = !w_prev0;
                w_gnt1 = w_prev0;
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdv0 <= 1'b0;
            r_rdv1 <= 1'b0;
            r_addr <= '0;
        end else begin
            r_rdv0 <= w_gnt0 & bus.m0_read;
            r_rdv1 <= w_gnt1 & bus.m1_read;
            if (w_acc) begin
                r_addr <= bus.ram_address;
            end
        end
    end

    assign bus.m0_waitrequest = reset | (w_req0 & ~w_gnt0);
    assign bus.m1_waitrequest = reset | (w_req1 & ~w_gnt1);

    assign bus.ram_chipselect = w_acc;
    assign bus.ram_write      = (w_gnt0 & bus.m0_write)
                              | (w_gnt1 & bus.m1_write);
    assign bus.ram_clken      = ~reset_req;

    // Idle cycles keep the last address so the RAM output stays stable.
    assign bus.ram_address    = w_gnt0 ? bus.m0_address
                              : w_gnt1 ? bus.m1_address
                              : r_addr;
    assign bus.ram_writedata  = w_gnt1 ? bus.m1_writedata
                              : bus.m0_writedata;
    assign bus.ram_byteenable = !bus.ram_write ? {BE_W{1'b1}}
                              : w_gnt1 ? bus.m1_byteenable
                              : bus.m0_byteenable;

    assign bus.m0_readdata      = bus.ram_readdata;
    assign bus.m1_readdata      = bus.ram_readdata;
    assign bus.m0_readdatavalid = r_rdv0 & ~reset;
    assign bus.m1_readdatavalid = r_rdv1 & ~reset;
endmodule

// File: doc/onchip_memory_port_arbiter.md
ONCHIP_MEMORY_PORT_ARBITER -- requirements
Module: onchip_memory_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word address width of the shared RAM port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock for all logic; RAM port is on the same clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reset_req  input  1  memory-freeze request; while high, no command is accepted.
REQ-006 m0_address, m1_address  input  ADDR_W  requester word address.
REQ-007 m0_byteenable, m1_byteenable  input  DATA_W/8  write byte lanes.
REQ-008 m0_read, m1_read / m0_write, m1_write  input  1  command strobes; read and write never both high on one requester.
REQ-009 m0_writedata, m1_writedata  input  DATA_W  write data.
REQ-010 m0_waitrequest, m1_waitrequest  output  1  high = command not accepted this cycle.
REQ-011 m0_readdata, m1_readdata  output  DATA_W  read data, both driven from ram_readdata.
REQ-012 m0_readdatavalid, m1_readdatavalid  output  1  read data valid for that requester.
REQ-013 ram_address  output  ADDR_W; ram_byteenable  output  DATA_W/8; ram_writedata  output  DATA_W.
REQ-014 ram_chipselect, ram_write, ram_clken  output  1  RAM port controls.
REQ-015 ram_readdata  input  DATA_W  RAM port output (address registered, data unregistered).

Function
REQ-016 Request mN_req = mN_read | mN_write; command accepted when mN_req & !mN_waitrequest.
REQ-017 At most one command accepted per cycle; accepted command drives ram_* combinationally that cycle with ram_chipselect=1, ram_write=mN_write, ram_clken=1.
REQ-018 No accepted command: ram_chipselect=0, ram_write=0, ram_clken=1 (unless reset_req), ram_address holds last driven value.
REQ-019 FSM states LAST0, LAST1 (requester most recently granted); reset state LAST1 so m0 wins the first contention.
REQ-020 Only one requester: it is granted regardless of state; both: grant the one not equal to LAST; state updates to granted requester on every acceptance, unchanged otherwise.
REQ-021 Non-granted requester with mN_req=1 SHALL see waitrequest=1; requester with mN_req=0 SHALL see waitrequest=0.
REQ-022 Read latency exactly 1 cycle: accepted read sets mN_readdatavalid high in the next cycle only, for the owning requester only.
REQ-023 Back-to-back reads (either requester, every cycle) SHALL sustain one readdatavalid per cycle, in acceptance order.
REQ-024 reset_req=1: both waitrequest=1 if requesting, ram_chipselect=0, ram_write=0, ram_clken=0; FSM frozen; a read accepted the cycle before still returns readdatavalid.
REQ-025 Write data/byteenable pass unmodified; byteenable ignored on reads (driven as all ones).

Reset
REQ-026 reset SHALL clear FSM to LAST1, readdatavalid pending flags to 0, ram_address register to 0.
REQ-027 During reset: all waitrequest=1, readdatavalid=0, ram_chipselect=0, ram_write=0; a read accepted in the cycle before reset SHALL NOT produce readdatavalid.

Configuration
REQ-028 Macro ONCHIP_ARB_LOCK_EN: when defined, ports m0_lock, m1_lock (input, 1) exist; a requester accepted with lock=1 owns the port exclusively (other requester waitrequest=1) until a cycle where owner's lock=0 and owner has no accepted command; state LOCK0/LOCK1 added.
REQ-029 Without ONCHIP_ARB_LOCK_EN: no lock ports, no LOCK states, pure round-robin per REQ-020.

Verification
REQ-030 m0 write 0x1234_5678 to addr 0x0010 be=0xF, then m1 read 0x0010 -> m1_readdatavalid one cycle after acceptance, m1_readdata=0x1234_5678, m0_readdatavalid=0.
REQ-031 m0 and m1 read every cycle for 8 cycles -> grants alternate m0,m1,m0,...; each gets 4 readdatavalid pulses, no cycle with both valid.
REQ-032 m1 write be=0x3 data 0xAAAA_BBBB over 0xFFFF_FFFF at 0x3FFF -> readback 0xFFFF_BBBB (top address, no wrap).
REQ-033 reset_req high 3 cycles during continuous m0 reads -> ram_clken=0, no acceptance, the read accepted before reset_req still returns valid; resumes next cycle after deassert.
REQ-034 Read accepted, reset asserted next cycle -> no readdatavalid; after reset, contention grants m0 first.
REQ-035 With ONCHIP_ARB_LOCK_EN: m1 lock=1 for 3 writes while m0 requests -> m0 waitrequest=1 throughout, m0 granted first cycle after m1 lock=0.
